// File: rtl/ddc_frame_packer_if.sv
// Stream bundle for the DDC frame packer: 96-bit burst input side and 128-bit framed output side.
// The slave modport is the packer's view, the master modport is the surrounding source/sink.
interface ddc_frame_packer_if;
  logic [95:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );
endinterface

// File: rtl/ddc_frame_packer.sv
// Packs channel-sequential DDC bursts into framed 128-bit stream packets (N_CH data beats + trailer).
// Whole frames are dropped when the output FIFO lacks room at burst start.
module ddc_frame_packer #(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int TS_WIDTH   = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear_stats,
  ddc_frame_packer_if.slave   bus,
  output logic [31:0]         frame_count,
  output logic [31:0]         drop_count,
  output logic                overflow,
  output logic                gap_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] NEED      = (AW+1)'(N_CH + 1);
  localparam logic [7:0]  LAST_BEAT = 8'(N_CH);

  typedef enum logic [1:0] {IDLE, COLLECT, TRAIL, DROP} state_t;
  state_t state, state_next;

  logic [128:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, space_ok, push, pop;
  logic [128:0]  push_word;

  logic [TS_WIDTH-1:0] ts;
  logic [31:0]   seq, seq_lat;
  logic [47:0]   ts_lat;
  logic [7:0]    beats;
  logic [15:0]   lost_since;
  logic          short_flag, gap_pending;
  logic          accept, drop_ev, gap_ev, burst_start, trail_wr, go_short;

  logic [47:0]   in_i, in_q;
  logic [127:0]  data_word, trailer_word;

  assign in_i = bus.s_axis_tdata[47:0];
  assign in_q = bus.s_axis_tdata[95:48];
  assign data_word = {{16{in_q[47]}}, in_q, {16{in_i[47]}}, in_i};
  assign trailer_word = {8'hA5, beats, 5'b0, short_flag, gap_pending, lost_since != 16'd0,
                         8'h00, ts_lat, lost_since, seq_lat};

  assign empty    = (count == '0);
  assign space_ok = (DEPTH - count) >= NEED;
  assign pop      = !empty && bus.m_axis_tready;

  assign bus.s_axis_tready = space_ok;
  assign bus.m_axis_tvalid = !empty;
  assign bus.m_axis_tdata  = empty ? '0 : mem[rd_ptr][127:0];
  assign bus.m_axis_tlast  = !empty && mem[rd_ptr][128];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    push        = 1'b0;
    push_word   = {1'b0, data_word};
    accept      = 1'b0;
    drop_ev     = 1'b0;
    gap_ev      = 1'b0;
    burst_start = 1'b0;
    trail_wr    = 1'b0;
    go_short    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_axis_tvalid) begin
          if (!enable) begin
            state_next = DROP;
          end else if (space_ok) begin
            burst_start = 1'b1;
            accept      = 1'b1;
            push        = 1'b1;
            state_next  = (N_CH == 1) ? TRAIL : COLLECT;
          end else begin
            burst_start = 1'b1;
            drop_ev     = 1'b1;
            state_next  = DROP;
          end
        end
      end
      COLLECT: begin
        if (bus.s_axis_tvalid) begin
          push = 1'b1;
          if (beats + 8'd1 == LAST_BEAT) state_next = TRAIL;
        end else begin
          go_short   = 1'b1;
          state_next = TRAIL;
        end
      end
      TRAIL: begin
        push      = 1'b1;
        push_word = {1'b1, trailer_word};
        trail_wr  = 1'b1;
        if (bus.s_axis_tvalid) begin
          gap_ev     = 1'b1;
          state_next = DROP;
        end else begin
          state_next = IDLE;
        end
      end
      DROP: begin
        if (!bus.s_axis_tvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A beat landing in the trailer cycle is flagged on the following frame's trailer, not this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts          <= '0;
      seq         <= '0;
      seq_lat     <= '0;
      ts_lat      <= '0;
      beats       <= '0;
      lost_since  <= '0;
      short_flag  <= 1'b0;
      gap_pending <= 1'b0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (burst_start) seq <= seq + 32'd1;
      if (accept) begin
        seq_lat    <= seq;
        ts_lat     <= 48'(ts);
        beats      <= 8'd1;
        short_flag <= 1'b0;
      end else if (push && !trail_wr) begin
        beats <= beats + 8'd1;
      end
      if (go_short) short_flag <= 1'b1;
      if (trail_wr) begin
        lost_since  <= '0;
        gap_pending <= bus.s_axis_tvalid;
      end else if (drop_ev && lost_since != 16'hFFFF) begin
        lost_since <= lost_since + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      gap_err     <= 1'b0;
    end else begin
      if (accept) frame_count <= frame_count + 32'd1;
      if (drop_ev && drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
      if (drop_ev) overflow <= 1'b1;
      if (gap_ev)  gap_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_ddc_frame_packer.sv
// Self-checking bench for ddc_frame_packer: frame-level reference model feeding a scoreboard,
// directed framing/overflow/gap/reset scenarios plus a long random-backpressure run.
module tb_ddc_frame_packer;

  localparam int N_CH  = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        clear_stats = 1'b0;
  logic [31:0] frame_count, drop_count;
  logic        overflow, gap_err;

  ddc_frame_packer_if bus ();

  ddc_frame_packer #(.N_CH(N_CH), .FIFO_DEPTH(DEPTH), .TS_WIDTH(48)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear_stats (clear_stats),
    .bus         (bus),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .gap_err     (gap_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [128:0] expQ[$];
  logic [31:0]  modelSeq, modelFrames, modelDrops;
  int           modelLost, modelUsed;
  bit           modelOverflow, modelGapErr, modelPendingGap;
  bit           noPop, monEnable, randReady;
  logic         readyLevel;
  logic [47:0]  cyc;

  // Timestamp reference: the free-running counter restarts at zero on reset.
  always @(posedge clk) cyc <= rst ? 48'd0 : cyc + 48'd1;

  task automatic checkOutput(input string tag, input logic [128:0] observed, input logic [128:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] dataWord(input logic [95:0] beat);
    logic signed [63:0] qExt, iExt;
    qExt = 64'($signed(beat[95:48]));
    iExt = 64'($signed(beat[47:0]));
    return {qExt, iExt};
  endfunction

  function automatic void resetModel();
    modelSeq        = '0;
    modelFrames     = '0;
    modelDrops      = '0;
    modelLost       = 0;
    modelUsed       = 0;
    modelOverflow   = 1'b0;
    modelGapErr     = 1'b0;
    modelPendingGap = 1'b0;
    expQ.delete();
  endfunction

  // One burst of nBeats followed by gapCycles idle cycles; the model predicts the whole frame at burst start.
  task automatic applyStimulus(input int nBeats, input int gapCycles, input bit clearAtStart,
                               input bit useFixed, input logic [95:0] fixedData);
    logic [95:0]  beatData[$];
    logic [127:0] t;
    int           written;
    bit           accepted;
    for (int b = 0; b < nBeats; b++)
      beatData.push_back(useFixed ? fixedData : {$urandom, $urandom, $urandom});
    for (int b = 0; b < nBeats; b++) begin
      @(posedge clk);
      #1;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = beatData[b];
      clear_stats       = clearAtStart && (b == 0);
      if (b == 0) begin
        accepted = !noPop || (modelUsed + N_CH + 1 <= DEPTH);
        t = '0;
        t[31:0] = modelSeq;
        modelSeq = modelSeq + 32'd1;
        if (accepted) begin
          written = (nBeats < N_CH) ? nBeats : N_CH;
          for (int k = 0; k < written; k++) expQ.push_back({1'b0, dataWord(beatData[k])});
          t[127:120] = 8'hA5;
          t[119:112] = 8'(written);
          t[106]     = nBeats < N_CH;
          t[105]     = modelPendingGap;
          t[104]     = modelLost != 0;
          t[95:48]   = cyc;
          t[47:32]   = (modelLost > 65535) ? 16'hFFFF : 16'(modelLost);
          expQ.push_back({1'b1, t});
          modelLost       = 0;
          modelPendingGap = nBeats > N_CH;
          modelFrames     = modelFrames + 32'd1;
          if (noPop) modelUsed += written + 1;
        end else begin
          modelLost++;
          if (modelDrops != 32'hFFFF_FFFF) modelDrops = modelDrops + 32'd1;
          modelOverflow = 1'b1;
        end
        if (clearAtStart) begin
          modelFrames   = '0;
          modelDrops    = '0;
          modelOverflow = 1'b0;
          modelGapErr   = 1'b0;
        end
        if (accepted && nBeats > N_CH) modelGapErr = 1'b1;
      end
    end
    for (int g = 0; g < gapCycles; g++) begin
      @(posedge clk);
      #1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = {$urandom, $urandom, $urandom};
      clear_stats       = 1'b0;
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_left", 129'(expQ.size()), 129'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkStats(input string tag);
    @(negedge clk);
    checkOutput({tag, "_frame_count"}, 129'(frame_count), 129'(modelFrames));
    checkOutput({tag, "_drop_count"},  129'(drop_count),  129'(modelDrops));
    checkOutput({tag, "_overflow"},    129'(overflow),    129'(modelOverflow));
    checkOutput({tag, "_gap_err"},     129'(gap_err),     129'(modelGapErr));
  endtask

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  // Scoreboard: every handshake pops one predicted word; a stalled word must not change.
  initial begin
    logic         stalled;
    logic [128:0] held, obs, expWord;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!monEnable) begin
        stalled = 1'b0;
      end else begin
        obs = {bus.m_axis_tlast, bus.m_axis_tdata};
        if (stalled) checkOutput("stall_hold", obs, held);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (expQ.size() == 0) begin
            checkOutput("extra_word_queue", 129'(expQ.size()), 129'd1);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("out_word", obs, expWord);
          end
        end
        stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
        held    = obs;
      end
    end
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    monEnable  = 1'b0;
    randReady  = 1'b0;
    readyLevel = 1'b1;
    noPop      = 1'b0;
    resetModel();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 129'(bus.m_axis_tvalid), 129'd0);
    checkOutput("rst_tlast",  129'(bus.m_axis_tlast),  129'd0);
    checkOutput("rst_tdata",  129'(bus.m_axis_tdata),  129'd0);
    checkOutput("rst_tready", 129'(bus.s_axis_tready), 129'd1);
    checkOutput("rst_frames", 129'(frame_count), 129'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    monEnable = 1'b1;

    // Single clean frame, I = -1, Q = 5
    applyStimulus(4, 6, 1'b0, 1'b1, {48'd5, 48'hFFFF_FFFF_FFFF});
    waitDrain(100);
    checkStats("t1");

    // Output stalled over 20 bursts: 12 fit, 8 dropped
    readyLevel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    noPop = 1'b1;
    modelUsed = 0;
    for (int f = 0; f < 20; f++) applyStimulus(4, 8, 1'b0, 1'b0, '0);
    checkStats("t2");
    checkOutput("t2_drop_count_8", 129'(drop_count), 129'd8);
    checkOutput("t2_tready_full", 129'(bus.s_axis_tready), 129'd0);
    noPop = 1'b0;
    readyLevel = 1'b1;
    waitDrain(300);
    applyStimulus(4, 6, 1'b0, 1'b0, '0);
    waitDrain(100);

    // Short burst, then an over-long burst and the two frames after it
    applyStimulus(3, 6, 1'b0, 1'b0, '0);
    waitDrain(100);
    applyStimulus(5, 6, 1'b0, 1'b0, '0);
    waitDrain(100);
    checkStats("t4");
    applyStimulus(4, 6, 1'b0, 1'b0, '0);
    applyStimulus(4, 6, 1'b0, 1'b0, '0);
    waitDrain(100);

    // Long run against random backpressure
    randReady = 1'b1;
    for (int f = 0; f < 1000; f++) applyStimulus(4, $urandom_range(8, 16), 1'b0, 1'b0, '0);
    randReady  = 1'b0;
    readyLevel = 1'b1;
    waitDrain(2000);
    checkStats("t5");

    // Reset in the middle of a frame
    readyLevel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    monEnable = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = {$urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    bus.s_axis_tdata  = {$urandom, $urandom, $urandom};
    @(negedge clk);
    checkOutput("t6_pre_tvalid", 129'(bus.m_axis_tvalid), 129'd1);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_rst_tvalid", 129'(bus.m_axis_tvalid), 129'd0);
    checkOutput("t6_rst_tlast",  129'(bus.m_axis_tlast),  129'd0);
    checkOutput("t6_rst_tdata",  129'(bus.m_axis_tdata),  129'd0);
    checkOutput("t6_rst_frames", 129'(frame_count), 129'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    readyLevel = 1'b1;
    monEnable  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(4, 6, 1'b0, 1'b0, '0);
    waitDrain(100);
    checkStats("t6");

    // clear_stats in the same cycle as an overflow drop
    readyLevel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    noPop = 1'b1;
    modelUsed = 0;
    for (int f = 0; f < 12; f++) applyStimulus(4, 8, 1'b0, 1'b0, '0);
    applyStimulus(4, 8, 1'b1, 1'b0, '0);
    checkStats("t6_clear");
    checkOutput("t6_clear_overflow", 129'(overflow), 129'd0);
    noPop = 1'b0;
    readyLevel = 1'b1;
    waitDrain(300);
    applyStimulus(4, 6, 1'b0, 1'b0, '0);
    waitDrain(100);
    checkStats("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
